// File: rtl/cpu_run_controller.sv
// Run/halt/step/breakpoint sequencer for the schoolRISCV soc; owns its clock enable and reset.
// Latency: a command takes effect SYNC_STAGES+1 edges after it is first sampled high; cpu_en is combinational.
// Backpressure: none; commands arriving while the soc is held in reset are consumed and dropped.
module cpu_run_controller #(
  parameter int PC_W        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int RST_CYCLES  = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_run,
  input  logic             cmd_step,
  input  logic             cmd_halt,
  input  logic             cmd_reset,
  input  logic             bp_en,
  input  logic [PC_W-1:0]  bp_addr,
  input  logic [PC_W-1:0]  pc,
  input  logic             pass,
  input  logic             fail,
  output logic             cpu_en,
  output logic             cpu_rst_n,
  output logic [2:0]       state,
  output logic             bp_hit,
  output logic [CNT_W-1:0] cycle_cnt
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_RUN    = 3'd1,
    S_STEP   = 3'd2,
    S_PAUSED = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [3:0] RST_LEN = 4'(RST_CYCLES);

  // Bit order of every command vector: {reset, halt, step, run}
  logic [3:0]                  cmd_in;
  logic [SYNC_STAGES-1:0][3:0] sync_q;
  logic [3:0]                  prev_q;
  logic [3:0]                  pulse;
  logic                        live;
  logic                        do_run;
  logic                        do_step;
  logic                        do_halt;
  logic                        do_reset;
  logic                        bp_cond;
  logic                        skip;
  logic [3:0]                  rst_cnt;
  state_t                      st;

  assign cmd_in = {cmd_reset, cmd_halt, cmd_step, cmd_run};
  assign pulse  = sync_q[SYNC_STAGES-1] & ~prev_q;

  // Soft reset always wins; the rest are priority-resolved and only honoured while the soc is out of reset
  assign do_reset = pulse[3];
  assign live     = cpu_rst_n & ~pulse[3];
  assign do_halt  = live & pulse[2];
  assign do_step  = live & pulse[1] & ~pulse[2];
  assign do_run   = live & pulse[0] & ~pulse[1] & ~pulse[2];

  // A breakpoint stops the soc before the matching instruction executes; skip lets it execute once on resume
  assign bp_cond = bp_en & (pc == bp_addr) & ~skip & (st == S_RUN);
  assign cpu_en  = ((st == S_RUN) | (st == S_STEP)) & cpu_rst_n & ~pass & ~fail & ~bp_cond;
  assign state   = st;

  // Command synchronizers followed by a previous-value flop for rising-edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], cmd_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Run-control state machine with its registered outputs, soc reset timer and enabled-cycle counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st        <= S_IDLE;
      cpu_rst_n <= 1'b0;
      rst_cnt   <= RST_LEN;
      bp_hit    <= 1'b0;
      skip      <= 1'b0;
      cycle_cnt <= '0;
    end else begin
      if (cpu_en && (cycle_cnt != '1)) begin
        cycle_cnt <= cycle_cnt + 1'b1;
      end
      if (cpu_en) begin
        skip <= 1'b0;
      end
      if (rst_cnt != 4'd0) begin
        rst_cnt <= rst_cnt - 4'd1;
        if (rst_cnt == 4'd1) begin
          cpu_rst_n <= 1'b1;
        end
      end

      if (do_reset) begin
        st        <= S_IDLE;
        cycle_cnt <= '0;
        bp_hit    <= 1'b0;
        skip      <= 1'b0;
        cpu_rst_n <= 1'b0;
        rst_cnt   <= RST_LEN;
      end else begin
        case (st)
          S_IDLE: begin
            if (do_run) begin
              st <= S_RUN;
            end else if (do_step) begin
              st <= S_STEP;
            end
          end
          S_RUN: begin
            if (pass || fail) begin
              st <= S_DONE;
            end else if (bp_cond) begin
              st     <= S_PAUSED;
              bp_hit <= 1'b1;
            end else if (do_halt) begin
              st <= S_PAUSED;
            end
          end
          S_STEP: begin
            st <= (pass || fail) ? S_DONE : S_PAUSED;
          end
          S_PAUSED: begin
            if (do_run || do_step) begin
              st     <= do_run ? S_RUN : S_STEP;
              skip   <= bp_hit;
              bp_hit <= 1'b0;
            end
          end
          S_DONE: begin
            st <= S_DONE;
          end
          default: begin
            st <= S_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cpu_run_controller.sv
// Bench for cpu_run_controller: directed scenarios then randomized commands against a behavioural model.
// The model advances once per clock edge; outputs are compared mid-cycle on the falling edge.
// A fake soc PC advances on the model's enabled cycles so breakpoints are reachable.
module tb_cpu_run_controller;

  localparam int IDLE = 0, RUN = 1, STEP = 2, PAUSED = 3, DONE = 4;
  localparam int RSTC = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_run = 1'b0, cmd_step = 1'b0, cmd_halt = 1'b0, cmd_reset = 1'b0;
  logic       bp_en = 1'b0;
  logic [3:0] bp_addr = 4'd0;
  logic [3:0] pc = 4'd0;
  logic       pass = 1'b0, fail = 1'b0;
  logic       cpu_en, cpu_rst_n, bp_hit;
  logic [2:0] state;
  logic [7:0] cycle_cnt;

  cpu_run_controller dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_run(cmd_run), .cmd_step(cmd_step), .cmd_halt(cmd_halt), .cmd_reset(cmd_reset),
    .bp_en(bp_en), .bp_addr(bp_addr), .pc(pc), .pass(pass), .fail(fail),
    .cpu_en(cpu_en), .cpu_rst_n(cpu_rst_n), .state(state), .bp_hit(bp_hit), .cycle_cnt(cycle_cnt)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, obs, exp);
    end
  endtask

  // Behavioural model state
  int        m_state, m_left, m_cnt, m_pc;
  bit        m_crst, m_bp_hit, m_skip;
  bit [3:0]  m_hist[$];   // sampled {reset,halt,step,run}, most recent first

  function automatic bit m_bp();
    return bp_en && (pc == bp_addr) && !m_skip && (m_state == RUN);
  endfunction

  function automatic bit m_en();
    return ((m_state == RUN) || (m_state == STEP)) && m_crst && !pass && !fail && !m_bp();
  endfunction

  task automatic model_reset();
    m_state = IDLE; m_left = RSTC; m_cnt = 0; m_pc = 0;
    m_crst = 0; m_bp_hit = 0; m_skip = 0;
    m_hist = '{4'd0, 4'd0, 4'd0};
    pc = 4'd0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("arst_state", state, IDLE);
    chk("arst_cpu_rst_n", cpu_rst_n, 0);
    chk("arst_cpu_en", cpu_en, 0);
    chk("arst_bp_hit", bp_hit, 0);
    chk("arst_cycle_cnt", cycle_cnt, 0);
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // One clock cycle: compare outputs, predict the next edge, then commit after it
  task automatic tick();
    bit       en, bp;
    bit [3:0] pul, smp;
    int       cmd;   // 0 none, 1 run, 2 step, 3 halt
    int       n_state, n_left, n_cnt, n_pc;
    bit       n_crst, n_bp_hit, n_skip;
    @(negedge clk);
    #1;
    bp = m_bp();
    en = m_en();
    chk("cpu_en", cpu_en, en);
    chk("state", state, m_state);
    chk("cpu_rst_n", cpu_rst_n, m_crst);
    chk("bp_hit", bp_hit, m_bp_hit);
    chk("cycle_cnt", cycle_cnt, m_cnt);
    smp = {cmd_reset, cmd_halt, cmd_step, cmd_run};
    pul = m_hist[1] & ~m_hist[2];
    n_state = m_state; n_left = m_left; n_cnt = m_cnt; n_crst = m_crst;
    n_bp_hit = m_bp_hit; n_skip = m_skip;
    n_pc = !m_crst ? 0 : (en ? (m_pc + 1) % 16 : m_pc);
    if (en) begin
      n_cnt  = (m_cnt < 255) ? m_cnt + 1 : 255;
      n_skip = 0;
    end
    if (m_left > 0) begin
      n_left = m_left - 1;
      if (n_left == 0) n_crst = 1;
    end
    if (pul[3]) begin
      n_state = IDLE; n_cnt = 0; n_bp_hit = 0; n_skip = 0; n_crst = 0; n_left = RSTC;
    end else begin
      cmd = !m_crst ? 0 : pul[2] ? 3 : pul[1] ? 2 : pul[0] ? 1 : 0;
      if (m_state == IDLE) begin
        if (cmd == 1) n_state = RUN;
        else if (cmd == 2) n_state = STEP;
      end else if (m_state == RUN) begin
        if (pass || fail) n_state = DONE;
        else if (bp) begin n_state = PAUSED; n_bp_hit = 1; end
        else if (cmd == 3) n_state = PAUSED;
      end else if (m_state == STEP) begin
        n_state = (pass || fail) ? DONE : PAUSED;
      end else if (m_state == PAUSED) begin
        if (cmd == 1 || cmd == 2) begin
          n_state = (cmd == 1) ? RUN : STEP;
          n_skip = m_bp_hit;
          n_bp_hit = 0;
        end
      end
    end
    @(posedge clk);
    #1;
    m_state = n_state; m_left = n_left; m_cnt = n_cnt; m_crst = n_crst;
    m_bp_hit = n_bp_hit; m_skip = n_skip; m_pc = n_pc;
    m_hist.push_front(smp);
    void'(m_hist.pop_back());
    pc = 4'(m_pc);
  endtask

  task automatic soft_reset();
    cmd_reset = 1'b1; tick(); cmd_reset = 1'b0;
    repeat (8) tick();
  endtask

  initial begin
    model_reset();
    #2 do_reset();

    // Power-on release and run
    repeat (6) tick();
    chk("por_release", cpu_rst_n, 1);
    cmd_run = 1'b1; repeat (3) tick(); cmd_run = 1'b0;
    repeat (10) tick();
    chk("run_state", state, RUN);
    chk("run_cnt", cycle_cnt, 10);

    // Single steps, then a held step command
    soft_reset();
    for (int i = 0; i < 3; i++) begin
      cmd_step = 1'b1; repeat (2) tick(); cmd_step = 1'b0; repeat (4) tick();
    end
    chk("step_cnt", cycle_cnt, 3);
    chk("step_state", state, PAUSED);
    cmd_step = 1'b1; repeat (20) tick(); cmd_step = 1'b0; repeat (4) tick();
    chk("step_hold_cnt", cycle_cnt, 4);

    // Breakpoint at pc 5, then resume
    bp_en = 1'b1; bp_addr = 4'd5;
    soft_reset();
    cmd_run = 1'b1; repeat (25) tick();
    chk("bp_state", state, PAUSED);
    chk("bp_hit", bp_hit, 1);
    chk("bp_pc", pc, 5);
    chk("bp_cnt", cycle_cnt, 5);
    cmd_run = 1'b0; repeat (2) tick(); cmd_run = 1'b1; repeat (5) tick();
    chk("bp_resume_state", state, RUN);
    chk("bp_resume_hit", bp_hit, 0);
    chk("bp_resume_pc", pc, 7);
    bp_en = 1'b0; cmd_run = 1'b0;

    // Pass stops the run; only soft reset exits DONE
    soft_reset();
    cmd_run = 1'b1; repeat (10) tick(); cmd_run = 1'b0;
    pass = 1'b1; tick();
    chk("pass_done", state, DONE);
    cmd_run = 1'b1; cmd_step = 1'b1; cmd_halt = 1'b1; repeat (5) tick();
    cmd_run = 1'b0; cmd_step = 1'b0; cmd_halt = 1'b0; repeat (2) tick();
    chk("done_sticky", state, DONE);
    cmd_reset = 1'b1; repeat (3) tick(); cmd_reset = 1'b0; pass = 1'b0;
    chk("done_reset_state", state, IDLE);
    chk("done_reset_rst", cpu_rst_n, 0);
    chk("done_reset_cnt", cycle_cnt, 0);
    repeat (6) tick();

    // Halt and step together from RUN: halt wins
    cmd_run = 1'b1; repeat (6) tick();
    cmd_halt = 1'b1; cmd_step = 1'b1; repeat (4) tick();
    chk("prio_state", state, PAUSED);
    cmd_halt = 1'b0; cmd_step = 1'b0; cmd_run = 1'b0; repeat (3) tick();

    // Counter saturation
    cmd_run = 1'b1; repeat (300) tick(); cmd_run = 1'b0;
    chk("sat_cnt", cycle_cnt, 255);
    chk("sat_state", state, RUN);

    // Randomized commands, flags, breakpoints and async resets
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 9) == 0) cmd_run   = ~cmd_run;
      if ($urandom_range(0, 9) == 0) cmd_step  = ~cmd_step;
      if ($urandom_range(0, 9) == 0) cmd_halt  = ~cmd_halt;
      if ($urandom_range(0, 29) == 0) cmd_reset = ~cmd_reset;
      pass = ($urandom_range(0, 60) == 0);
      fail = ($urandom_range(0, 60) == 0);
      if ($urandom_range(0, 199) == 0) begin
        bp_en = 1'($urandom_range(0, 1));
        bp_addr = 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 499) == 0) do_reset();
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/cpu_run_controller.md
Name: cpu_run_controller

Overview:
- Sequences execution of the schoolRISCV soc: run, halt, single-step, PC breakpoint, soft CPU reset.
- Drives the soc clock-enable and reset, and stops automatically on pass/fail.
- Sits between the TinyTapeout pins (ui_in commands) and the soc instance.
- Exposes run state and a retired-cycle counter for display on uo_out/uio_out.

Parameters:
- PC_W, 4, width of soc PC and breakpoint address
- SYNC_STAGES, 2, synchronizer flops on each command input (min 2)
- RST_CYCLES, 4, soc reset hold length after a soft-reset command (1..15)
- CNT_W, 8, enabled-cycle counter width

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset of this block
- cmd_run  in  1  async level; rising edge = run
- cmd_step  in  1  async level; rising edge = execute one cycle
- cmd_halt  in  1  async level; rising edge = halt
- cmd_reset  in  1  async level; rising edge = soft reset of soc
- bp_en  in  1  breakpoint enable (static; no sync required)
- bp_addr  in  PC_W  breakpoint PC (static)
- pc  in  PC_W  current soc PC
- pass  in  1  soc pass flag
- fail  in  1  soc fail flag
- cpu_en  out  1  soc clock enable; combinational from state and inputs
- cpu_rst_n  out  1  soc reset, active low; registered
- state  out  3  0=IDLE 1=RUN 2=STEP 3=PAUSED 4=DONE
- bp_hit  out  1  sticky; set on breakpoint stop, cleared on leaving PAUSED
- cycle_cnt  out  CNT_W  count of cycles with cpu_en=1; saturating

Behaviour:
- Reset is asynchronous and active-low: rst_n=0 forces the values below immediately, independent of clk.
  - state=IDLE, cpu_rst_n=0, bp_hit=0, cycle_cnt=0, skip=0, synchronizers/edge flops=0.
  - Release is synchronous: cpu_rst_n stays 0 for RST_CYCLES edges after rst_n rises, then goes 1.
- Command path:
  - Each cmd_* passes through SYNC_STAGES flops, then a previous-value flop; pulse = sync & ~prev.
  - State acts on a pulse at the edge that follows it.
  - Effect is therefore visible after edge SYNC_STAGES+1, counting the first edge that samples the input high.
  - Holding an input high gives exactly one pulse.
- Pulse priority when simultaneous: reset > halt > step > run. Lower-priority pulses in that cycle are dropped.
- Soft reset pulse, from any state:
  - state=IDLE, cycle_cnt=0, bp_hit=0, skip=0.
  - cpu_rst_n=0 for exactly RST_CYCLES cycles, then 1.
  - All other pulses are ignored while cpu_rst_n=0.
- Transitions:
  - IDLE: run -> RUN; step -> STEP.
  - RUN: halt -> PAUSED; pass|fail -> DONE; breakpoint -> PAUSED with bp_hit=1.
  - STEP: always leaves after one cycle. Goes to DONE if pass|fail, else PAUSED.
  - PAUSED: run -> RUN; step -> STEP. On exit set skip=1 if bp_hit, then clear bp_hit.
  - DONE: only soft reset exits. run/step/halt ignored.
- Breakpoint condition: bp_en & (pc==bp_addr) & ~skip & state==RUN.
- cpu_en = (state==RUN | state==STEP) & cpu_rst_n & ~pass & ~fail & ~breakpoint_condition.
  - The breakpointed instruction is NOT executed before the stop.
  - STEP may execute at a breakpoint PC; breakpoints apply only in RUN.
- skip clears after the first cycle with cpu_en=1, so resuming from a breakpoint executes that instruction once.
- pass/fail dominate halt and breakpoint in the same cycle: DONE wins.
- cycle_cnt increments on each edge where cpu_en=1 and saturates at all-ones (no wrap).
- Halt in IDLE/PAUSED/DONE is a no-op. Run in RUN and step in STEP are no-ops.

Test Plan:
- Reset/run: hold rst_n=0 -> cpu_rst_n=0, state=0, cpu_en=0, cycle_cnt=0; release -> cpu_rst_n=1 after 4 edges. Raise cmd_run -> state=1 and cpu_en=1 after edge 3; cycle_cnt increments every cycle thereafter.
- Step: from IDLE raise cmd_step 3 times, with gaps -> each gives exactly one cpu_en=1 cycle; cycle_cnt=3, state=3. Holding cmd_step high 20 cycles -> only one step.
- Breakpoint: bp_en=1, bp_addr=5, run; when pc=5 -> cpu_en=0 that cycle, state=3, bp_hit=1, pc stays 5. cmd_run -> pc advances past 5 (one enabled cycle at pc=5), bp_hit=0, state=1.
- Pass/fail: drive pass=1 while RUN -> cpu_en=0 same cycle, state=4 next edge. cmd_run/step/halt then have no effect; cmd_reset -> state=0, cpu_rst_n low for 4 cycles, cycle_cnt=0.
- Priority/saturation: pulse cmd_halt and cmd_step in the same cycle from RUN -> PAUSED, no step. Run 300 cycles -> cycle_cnt=255 held.
- Async reset mid-run: rst_n low between edges -> all outputs at reset values immediately.
